// File: rtl/aoa_tracker.sv
// aoa_tracker: multi-channel angle-of-arrival accumulator.
// Stage 1 turns ddiff into a signed delta; stage 2 does the saturating or wrapping read-modify-write.
module aoa_tracker #(
  parameter int DDIFF_BITS = 9,
  parameter int AOA_BITS   = 8,
  parameter int CHANNELS   = 4,
  parameter int SHIFT      = 4,
  parameter int AOA_INIT   = 128,
  parameter int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         init,
  input  logic                         in_valid,
  input  logic [CH_BITS-1:0]           in_chan,
  input  logic [DDIFF_BITS-1:0]        ddiff,
  input  logic                         wrap_mode,
  input  logic                         sat_clr,
  output logic                         out_valid,
  output logic [CH_BITS-1:0]           out_chan,
  output logic [AOA_BITS-1:0]          out_aoa,
  output logic [CHANNELS*AOA_BITS-1:0] aoa_flat,
  output logic [CHANNELS-1:0]          sat_hi,
  output logic [CHANNELS-1:0]          sat_lo
);
  localparam int DW = DDIFF_BITS + 1;
  localparam int SW = ((AOA_BITS > DW) ? AOA_BITS : DW) + 2;
  localparam logic [DW-1:0]        CENTRE = DW'(2 ** (DDIFF_BITS - 1));
  localparam logic [DW-1:0]        ROUND  = DW'(2 ** SHIFT - 1);
  localparam logic signed [SW-1:0] MAX_S  = SW'(2 ** AOA_BITS - 1);
  localparam logic [AOA_BITS-1:0]  INIT_V = AOA_BITS'(AOA_INIT);

  logic [CHANNELS-1:0][AOA_BITS-1:0] acc_r;
  logic                   s1_valid_r;
  logic [CH_BITS-1:0]     s1_chan_r;
  logic signed [DW-1:0]   s1_delta_r;
  logic                   out_valid_r;
  logic [CH_BITS-1:0]     out_chan_r;
  logic [AOA_BITS-1:0]    out_aoa_r;
  logic [CHANNELS-1:0]    sat_hi_r, sat_lo_r;

  logic signed [DW-1:0]   diff_s, biased_s, delta_s;
  logic                   chan_ok_s;
  logic [AOA_BITS-1:0]    cur_s, result_s;
  logic signed [SW-1:0]   sum_s;
  logic                   over_s, under_s;
  logic [CHANNELS-1:0]    set_hi_s, set_lo_s;

  // Stage 1: signed delta, truncated toward zero by biasing negatives before the arithmetic shift
  always_comb begin
    diff_s = CENTRE - {1'b0, ddiff};
    if (diff_s[DW-1]) begin
      biased_s = diff_s + ROUND;
    end else begin
      biased_s = diff_s;
    end
    delta_s   = biased_s >>> SHIFT;
    chan_ok_s = ({1'b0, in_chan} < (CH_BITS + 1)'(CHANNELS));
  end

  // Stage 2: unclipped sum, overflow detection and mode-dependent result
  always_comb begin
    cur_s   = acc_r[s1_chan_r];
    sum_s   = $signed({{(SW - AOA_BITS){1'b0}}, cur_s}) + {{(SW - DW){s1_delta_r[DW-1]}}, s1_delta_r};
    over_s  = (sum_s > MAX_S);
    under_s = sum_s[SW-1];
    case ({wrap_mode, over_s, under_s})
      3'b010:  result_s = {AOA_BITS{1'b1}};
      3'b001:  result_s = {AOA_BITS{1'b0}};
      default: result_s = sum_s[AOA_BITS-1:0];
    endcase
    for (int k = 0; k < CHANNELS; k++) begin
      set_hi_s[k] = s1_valid_r && !init && over_s  && (s1_chan_r == CH_BITS'(k));
      set_lo_s[k] = s1_valid_r && !init && under_s && (s1_chan_r == CH_BITS'(k));
    end
  end

  // Pipeline, accumulators and result strobe; init outranks everything but reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r       <= {CHANNELS{INIT_V}};
      s1_valid_r  <= 1'b0;
      s1_chan_r   <= {CH_BITS{1'b0}};
      s1_delta_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
      out_chan_r  <= {CH_BITS{1'b0}};
      out_aoa_r   <= {AOA_BITS{1'b0}};
    end else if (init) begin
      acc_r       <= {CHANNELS{INIT_V}};
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      s1_valid_r  <= in_valid && chan_ok_s;
      s1_chan_r   <= in_chan;
      s1_delta_r  <= delta_s;
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        acc_r[s1_chan_r] <= result_s;
        out_chan_r       <= s1_chan_r;
        out_aoa_r        <= result_s;
      end
    end
  end

  // Sticky flags: a set event beats a simultaneous clear for the same bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_hi_r <= {CHANNELS{1'b0}};
      sat_lo_r <= {CHANNELS{1'b0}};
    end else if (sat_clr) begin
      sat_hi_r <= set_hi_s;
      sat_lo_r <= set_lo_s;
    end else begin
      sat_hi_r <= sat_hi_r | set_hi_s;
      sat_lo_r <= sat_lo_r | set_lo_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;
  assign out_aoa   = out_aoa_r;
  assign aoa_flat  = acc_r;
  assign sat_hi    = sat_hi_r;
  assign sat_lo    = sat_lo_r;
endmodule

// File: tb/tb_aoa_tracker.sv
// Self-checking bench for aoa_tracker: directed scenarios plus random traffic against an integer model.
module tb_aoa_tracker;
  localparam int CH = 4;

  logic        clk = 1'b0, reset_n = 1'b0, init = 1'b0, in_valid = 1'b0;
  logic        wrap_mode = 1'b0, sat_clr = 1'b0;
  logic [1:0]  in_chan = 2'd0;
  logic [8:0]  ddiff = 9'd0;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic [7:0]  out_aoa;
  logic [31:0] aoa_flat;
  logic [3:0]  sat_hi, sat_lo;

  logic        in_valid6 = 1'b0;
  logic [2:0]  in_chan6 = 3'd0;
  logic        out_valid6;
  logic [2:0]  out_chan6;
  logic [7:0]  out_aoa6;
  logic [47:0] aoa_flat6;
  logic [5:0]  sat_hi6, sat_lo6;

  int n_checks = 0, n_fail = 0;

  // Reference model state
  int acc_m[CH];
  bit hi_m[CH], lo_m[CH];
  bit ov_m;
  int oc_m, oa_m;
  bit pv_m;
  int pc_m, pd_m;

  aoa_tracker dut (
    .clk(clk), .reset_n(reset_n), .init(init), .in_valid(in_valid), .in_chan(in_chan),
    .ddiff(ddiff), .wrap_mode(wrap_mode), .sat_clr(sat_clr), .out_valid(out_valid),
    .out_chan(out_chan), .out_aoa(out_aoa), .aoa_flat(aoa_flat), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  aoa_tracker #(.CHANNELS(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .init(init), .in_valid(in_valid6), .in_chan(in_chan6),
    .ddiff(ddiff), .wrap_mode(wrap_mode), .sat_clr(sat_clr), .out_valid(out_valid6),
    .out_chan(out_chan6), .out_aoa(out_aoa6), .aoa_flat(aoa_flat6), .sat_hi(sat_hi6), .sat_lo(sat_lo6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flat_m();
    logic [31:0] r;
    for (int k = 0; k < CH; k++) r[k*8 +: 8] = 8'(acc_m[k]);
    return r;
  endfunction

  function automatic logic [3:0] pack_m(input bit hi);
    logic [3:0] r;
    for (int k = 0; k < CH; k++) r[k] = hi ? hi_m[k] : lo_m[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      acc_m[k] = 128; hi_m[k] = 1'b0; lo_m[k] = 1'b0;
    end
    ov_m = 1'b0; oc_m = 0; oa_m = 0; pv_m = 1'b0;
  endtask

  // One clock edge of the specified behaviour, in plain integer arithmetic
  task automatic model_edge(input bit v, input int ch, input int dd, input bit wm, input bit sc, input bit ii);
    int sum, res;
    if (sc) for (int k = 0; k < CH; k++) begin hi_m[k] = 1'b0; lo_m[k] = 1'b0; end
    ov_m = 1'b0;
    if (ii) begin
      for (int k = 0; k < CH; k++) acc_m[k] = 128;
      pv_m = 1'b0;
    end else begin
      if (pv_m) begin
        sum = acc_m[pc_m] + pd_m;
        if (sum > 255) hi_m[pc_m] = 1'b1;
        if (sum < 0)   lo_m[pc_m] = 1'b1;
        if (wm)            res = ((sum % 256) + 256) % 256;
        else if (sum > 255) res = 255;
        else if (sum < 0)   res = 0;
        else                res = sum;
        acc_m[pc_m] = res; ov_m = 1'b1; oc_m = pc_m; oa_m = res;
      end
      pv_m = v && (ch < CH);
      pc_m = ch;
      pd_m = (256 - dd) / 16;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_out_valid"}, out_valid, ov_m);
    check({tag, "_out_chan"},  out_chan,  oc_m);
    check({tag, "_out_aoa"},   out_aoa,   oa_m);
    check({tag, "_aoa_flat"},  aoa_flat,  flat_m());
    check({tag, "_sat_hi"},    sat_hi,    pack_m(1'b1));
    check({tag, "_sat_lo"},    sat_lo,    pack_m(1'b0));
  endtask

  task automatic step(input string tag, input bit v, input int ch, input int dd,
                      input bit wm, input bit sc, input bit ii);
    in_valid = v; in_chan = ch[1:0]; ddiff = dd[8:0];
    wrap_mode = wm; sat_clr = sc; init = ii;
    @(posedge clk);
    model_edge(v, ch, dd, wm, sc, ii);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check("reset_flat_literal", aoa_flat, 32'h80808080);
    check("reset6_flat", aoa_flat6, {6{8'h80}});
    reset_n = 1'b1;

    // Idle after reset
    repeat (3) step("t1", 0, 0, 0, 0, 0, 0);

    // Single ch0 sample, +16
    step("t2a", 1, 0, 0, 0, 0, 0);
    check("t2_stage1_quiet", out_valid, 1'b0);
    step("t2b", 0, 0, 0, 0, 0, 0);
    check("t2_valid", out_valid, 1'b1);
    check("t2_aoa", out_aoa, 8'h90);
    check("t2_flat", aoa_flat, 32'h80808090);
    step("t2c", 0, 0, 0, 0, 0, 0);
    check("t2_single_pulse", out_valid, 1'b0);

    // Nine -15 steps on ch1, saturating at 0
    for (int i = 0; i < 9; i++) begin
      step("t3", 1, 1, 511, 0, 0, 0);
      if (i > 0) check("t3_aoa", out_aoa, 128 - 15 * i);
    end
    check("t3_lo_not_yet", sat_lo[1], 1'b0);
    step("t3e", 0, 0, 0, 0, 0, 0);
    check("t3_floor", out_aoa, 8'h00);
    check("t3_sat_lo1", sat_lo[1], 1'b1);
    check("t3_sat_hi", sat_hi, 4'h0);

    // Eight +16 steps on ch2 with wrap, then again saturating after init
    for (int i = 0; i < 8; i++) begin
      step("t4w", 1, 2, 0, 1, 0, 0);
      if (i > 0) check("t4w_aoa", out_aoa, 128 + 16 * i);
    end
    step("t4we", 0, 0, 0, 1, 0, 0);
    check("t4_wrapped", out_aoa, 8'h00);
    check("t4_sat_hi2", sat_hi[2], 1'b1);
    step("t4i", 0, 0, 0, 0, 0, 1);
    check("t4_init_flat", aoa_flat, 32'h80808080);
    for (int i = 0; i < 8; i++) step("t4s", 1, 2, 0, 0, 0, 0);
    step("t4se", 0, 0, 0, 0, 0, 0);
    check("t4_ceiling", out_aoa, 8'hFF);

    // init while a ch3 sample sits in stage 1, with another sample presented
    step("t5a", 1, 3, 0, 0, 0, 0);
    step("t5b", 1, 0, 0, 0, 0, 1);
    check("t5_no_valid", out_valid, 1'b0);
    check("t5_flat", aoa_flat, 32'h80808080);
    step("t5c", 0, 0, 0, 0, 0, 0);
    check("t5_no_valid_late", out_valid, 1'b0);
    check("t5_flat_late", aoa_flat, 32'h80808080);
    check("t5_hi_kept", sat_hi, 4'b0100);
    check("t5_lo_kept", sat_lo, 4'b0010);

    // sat_clr alone, then sat_clr colliding with a new sat_lo[1] event
    step("t6a", 0, 0, 0, 0, 1, 0);
    check("t6_clr_hi", sat_hi, 4'h0);
    check("t6_clr_lo", sat_lo, 4'h0);
    for (int i = 0; i < 9; i++) step("t6b", 1, 1, 511, 0, 0, 0);
    step("t6c", 0, 0, 0, 0, 1, 0);
    check("t6_set_wins", sat_lo[1], 1'b1);
    step("t6d", 0, 0, 0, 0, 1, 0);
    check("t6_clr_again", sat_lo, 4'h0);

    // Six-channel build: channels 6 and 7 are dropped, channel 5 works
    in_valid6 = 1'b1; in_chan6 = 3'd6;
    step("t7a", 0, 0, 0, 0, 0, 0);
    in_chan6 = 3'd7;
    step("t7b", 0, 0, 0, 0, 0, 0);
    in_valid6 = 1'b0;
    check("t7_drop_valid_a", out_valid6, 1'b0);
    step("t7c", 0, 0, 0, 0, 0, 0);
    check("t7_drop_valid_b", out_valid6, 1'b0);
    check("t7_drop_flat", aoa_flat6, {6{8'h80}});
    check("t7_drop_flags", {sat_hi6, sat_lo6}, 12'h000);
    in_valid6 = 1'b1; in_chan6 = 3'd5;
    step("t7d", 0, 0, 0, 0, 0, 0);
    in_valid6 = 1'b0;
    step("t7e", 0, 0, 0, 0, 0, 0);
    check("t7_ch5_valid", out_valid6, 1'b1);
    check("t7_ch5_chan", out_chan6, 3'd5);
    check("t7_ch5_aoa", out_aoa6, 8'h90);
    check("t7_ch5_flat", aoa_flat6, {8'h90, {5{8'h80}}});

    // Random traffic, with one asynchronous reset while a sample is in flight
    for (int i = 0; i < 500; i++) begin
      int sel, dd;
      bit ii, sc;
      sel = $urandom_range(0, 3);
      dd  = (sel == 0) ? 0 : (sel == 1) ? 511 : $urandom_range(0, 511);
      ii  = ($urandom_range(0, 49) == 0);
      sc  = !ii && ($urandom_range(0, 19) == 0);
      if (i == 250) begin
        in_valid = 1'b1; in_chan = 2'd3; ddiff = 9'd0; init = 1'b0; sat_clr = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 3, 0, wrap_mode, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_all("midrst");
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step("postrst", 0, 0, 0, 0, 0, 0);
      end
      step("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 3), dd,
           1'($urandom_range(0, 1)), sc, ii);
    end
    repeat (2) step("drain", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
